// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for the core's data-memory request port. It takes
//   one load/store at a time through a valid/ready handshake. It spends
//   WAIT_STATES cycles in WAIT, then commits the access on the edge that
//   enters RESP. The response is held until rsp_ready is seen.
//   Loads and stores follow RV32I byte/half/word selection on funct3.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake (req_ready is combinational)
//   req_we              : 1 = store, 0 = load
//   req_funct3          : RV32I load/store funct3
//   req_addr            : byte address (word index = addr[31:2])
//   req_wdata           : store data (low byte/half used for SB/SH)
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : extended load data, 0 for stores and errors
//   rsp_err             : illegal request, no memory effect
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int              CW        = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int              AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CW-1:0]   CNT_LAST  = CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [29:0]     DEPTH_LIM = 30'(DEPTH_WORDS);
  localparam logic            NO_WAIT   = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept_s;
  logic          commit_s;
  logic          op_we_s;
  logic [2:0]    op_f3_s;
  logic [31:0]   op_addr_s;
  logic [31:0]   op_wdata_s;
  logic          err_s;
  logic [AW-1:0] idx_s;
  logic [31:0]   rd_word_s;
  logic [31:0]   wr_word_s;
  logic [31:0]   ld_data_s;

  // Illegal funct3, misalignment or out-of-range word index.
  function automatic logic is_illegal(input logic we, input logic [2:0] f3,
                                      input logic [31:0] addr, input logic [29:0] lim);
    logic bad_f3;
    logic misal;
    case (f3)
      3'b000, 3'b001, 3'b010: bad_f3 = 1'b0;
      3'b100, 3'b101:         bad_f3 = we;
      default:                bad_f3 = 1'b1;
    endcase
    misal = ((f3[1:0] == 2'b01) && addr[0]) ||
            ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    return bad_f3 || misal || (addr[31:2] >= lim);
  endfunction

  // Lane select plus sign/zero extension for loads.
  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {lane, 3'b000});
    h = 16'(word >> {lane[1], 4'b0000});
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Merge store data into the existing word; untouched lanes keep their value.
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [2:0] f3, input logic [1:0] lane);
    logic [31:0] r;
    r = word;
    case (f3[1:0])
      2'b00:   r[{lane, 3'b000} +: 8]     = wdata[7:0];
      2'b01:   r[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      2'b10:   r = wdata;
      default: r = word;
    endcase
    return r;
  endfunction

  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign accept_s  = req_valid && req_ready;

  // Operand source: live inputs when committing straight from IDLE, captured copy otherwise.
  always_comb begin
    if (state_q == ST_IDLE) begin
      op_we_s    = req_we;
      op_f3_s    = req_funct3;
      op_addr_s  = req_addr;
      op_wdata_s = req_wdata;
    end else begin
      op_we_s    = we_q;
      op_f3_s    = f3_q;
      op_addr_s  = addr_q;
      op_wdata_s = wdata_q;
    end
  end

  assign err_s     = is_illegal(op_we_s, op_f3_s, op_addr_s, DEPTH_LIM);
  assign idx_s     = op_addr_s[AW+1:2];
  assign rd_word_s = mem[idx_s];
  assign wr_word_s = store_merge(rd_word_s, op_wdata_s, op_f3_s, op_addr_s[1:0]);
  assign ld_data_s = load_ext(rd_word_s, op_f3_s, op_addr_s[1:0]);

  // Commit happens only on the edge that moves the FSM into RESP; reset suppresses it.
  assign commit_s = !rst &&
                    (((state_q == ST_IDLE) && accept_s && NO_WAIT) ||
                     ((state_q == ST_WAIT) && (cnt_q == CNT_LAST)));

  // Next-state, capture and response computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = {CW{1'b0}};
          state_d = NO_WAIT ? ST_RESP : ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (commit_s) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = err_s;
      rsp_rdata_d = (err_s || op_we_s) ? 32'd0 : ld_data_s;
    end else if ((state_q == ST_RESP) && rsp_ready) begin
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = 32'd0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CW{1'b0}};
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Data array write; contents are deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (commit_s && op_we_s && !err_s) begin
      mem[idx_s] <= wr_word_s;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed, scoreboarded bench for data_mem_responder. Index 0 is a
// WAIT_STATES=2 instance and index 1 is a WAIT_STATES=0 instance.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [1:0][2:0]  req_funct3;
  logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;

  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] sb_q[$];

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_dut_ws2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request on instance w, check latency and scoreboarded response.
  // Must be called right after a falling edge with instance w idle.
  task automatic do_req(input int w, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int hold, input string tag);
    int lat;
    int ws;
    logic [32:0] e;
    ws = (w == 0) ? 2 : 0;
    sb_q.push_back({exp_err, exp_rdata});
    req_valid[w]  = 1'b1;
    req_we[w]     = we;
    req_funct3[w] = f3;
    req_addr[w]   = addr;
    req_wdata[w]  = wdata;
    lat = 0;
    while (!req_ready[w] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " req_ready"}, {31'd0, req_ready[w]}, 32'd1);
    // Accept happens on the next rising edge; scramble inputs afterwards.
    @(negedge clk);
    lat = 1;
    req_valid[w] = 1'b0;
    req_addr[w]  = 32'hFFFF_FFFC;
    req_wdata[w] = ~wdata;
    while (!rsp_valid[w] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(ws + 1));
    e = sb_q.pop_front();
    check({tag, " rdata"}, rsp_rdata[w], e[31:0]);
    check({tag, " err"}, {31'd0, rsp_err[w]}, {31'd0, e[32]});
    if (hold > 0) begin
      // A competing store that must never be accepted while the response is held.
      req_valid[w]  = 1'b1;
      req_we[w]     = 1'b1;
      req_funct3[w] = 3'b010;
      req_addr[w]   = 32'h10;
      req_wdata[w]  = 32'h0BAD_BAD0;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold valid"}, {31'd0, rsp_valid[w]}, 32'd1);
      check({tag, " hold rdata"}, rsp_rdata[w], e[31:0]);
      check({tag, " hold req_ready"}, {31'd0, req_ready[w]}, 32'd0);
    end
    req_valid[w] = 1'b0;
    rsp_ready[w] = 1'b1;
    @(negedge clk);
    rsp_ready[w] = 1'b0;
    check({tag, " post valid"}, {31'd0, rsp_valid[w]}, 32'd0);
    check({tag, " post req_ready"}, {31'd0, req_ready[w]}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_we     = '0;
    rsp_ready  = '0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("reset rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    check("reset rsp_rdata", rsp_rdata[0], 32'd0);
    check("reset rsp_err", {31'd0, rsp_err[0]}, 32'd0);
    check("reset req_ready", {30'd0, req_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle req_ready", {30'd0, req_ready}, 32'd3);

    // Word store/load and lane selection
    do_req(0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, "sw 10");
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, "lw 10");
    do_req(0, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0, 0, "lb 13");
    do_req(0, 1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_00DE, 1'b0, 0, "lbu 13");
    do_req(0, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_DEAD, 1'b0, 0, "lh 12");
    do_req(0, 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000_BEEF, 1'b0, 0, "lhu 10");

    // Sub-word stores merge into the existing word
    do_req(0, 1'b1, 3'b000, 32'h11, 32'hAAAA_AA55, 32'h0, 1'b0, 0, "sb 11");
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_55EF, 1'b0, 0, "lw after sb");
    do_req(0, 1'b1, 3'b001, 32'h12, 32'hBBBB_1234, 32'h0, 1'b0, 0, "sh 12");
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234_55EF, 1'b0, 0, "lw after sh");

    // Illegal requests
    do_req(0, 1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1, 0, "lw misaligned");
    do_req(0, 1'b1, 3'b001, 32'h13, 32'hFFFF_FFFF, 32'h0, 1'b1, 0, "sh misaligned");
    do_req(0, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 0, "load f3 011");
    do_req(0, 1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b1, 0, "store f3 100");
    do_req(0, 1'b1, 3'b010, 32'h1000, 32'h1111_2222, 32'h0, 1'b1, 0, "sw out of range");
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234_55EF, 1'b0, 0, "lw after errors");

    // Held response with a competing request in the window
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234_55EF, 1'b0, 5, "lw held");
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234_55EF, 1'b0, 0, "lw after hold");

    // Reset during WAIT drops a pending store
    do_req(0, 1'b1, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0, 0, "sw 20 zero");
    req_valid[0]  = 1'b1;
    req_we[0]     = 1'b1;
    req_funct3[0] = 3'b010;
    req_addr[0]   = 32'h20;
    req_wdata[0]  = 32'hCAFE_F00D;
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("wait req_ready", {31'd0, req_ready[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid rst rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    check("mid rst rsp_rdata", rsp_rdata[0], 32'd0);
    check("mid rst rsp_err", {31'd0, rsp_err[0]}, 32'd0);
    check("mid rst req_ready", {31'd0, req_ready[0]}, 32'd0);
    // Request offered while reset is asserted must not be accepted
    req_valid[0]  = 1'b1;
    req_we[0]     = 1'b0;
    req_addr[0]   = 32'h10;
    @(negedge clk);
    rst          = 1'b0;
    req_valid[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst+valid no rsp", {31'd0, rsp_valid[0]}, 32'd0);
    end
    check("after rst req_ready", {31'd0, req_ready[0]}, 32'd1);
    do_req(0, 1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0, 0, "lw 20 after rst");

    // Zero-wait-state instance
    do_req(1, 1'b1, 3'b010, 32'h20, 32'hCAFE_F00D, 32'h0, 1'b0, 0, "ws0 sw 20");
    do_req(1, 1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFE_F00D, 1'b0, 0, "ws0 lw 20");
    do_req(1, 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF_CAFE, 1'b0, 0, "ws0 lh 22");
    do_req(1, 1'b0, 3'b001, 32'h21, 32'h0, 32'h0, 1'b1, 0, "ws0 lh misaligned");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
